// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register for the 16-bit CPU.
// Latches the execute-stage results for the mem stage. RAM2 is shared with
// instruction fetch, so a RAM2 load/store is frozen in place for
// RAM2_HOLD_CYCLES cycles while the upstream stages are asked to stall.
// Also provides bubble insertion (flush) and an external freeze (hold).

package ex_mem_pkg;

  // Access kind carried alongside every instruction.
  typedef enum logic [1:0] {
    RWE_NOTHING   = 2'b00,
    RWE_WRITE_REG = 2'b01,
    RWE_READ_MEM  = 2'b10,
    RWE_WRITE_MEM = 2'b11
  } rwe_e;

  // A memory access targets RAM2 when address bit 15 is clear.
  function automatic logic is_ram2(input logic [1:0] rwe, input logic [15:0] addr);
    return ((rwe == RWE_READ_MEM) || (rwe == RWE_WRITE_MEM)) && !addr[15];
  endfunction

endpackage

module ex_mem_latch
  import ex_mem_pkg::*;
#(
  parameter int unsigned RAM2_HOLD_CYCLES = 2,
  parameter logic [15:0] NOP_INSTR        = 16'h0800
) (
  input  logic        exmemi_clk,
  input  logic        exmemi_rst,
  input  logic [15:0] exmemi_instr,
  input  logic [15:0] exmemi_pc,
  input  logic [15:0] exmemi_data,
  input  logic [3:0]  exmemi_wreg_addr,
  input  logic [15:0] exmemi_write_to_mem_data,
  input  logic [1:0]  exmemi_rwe,
  input  logic        exmemi_hold,
  input  logic        exmemi_flush,
  output logic [15:0] exmemo_instr,
  output logic [15:0] exmemo_pc,
  output logic [15:0] exmemo_data,
  output logic [3:0]  exmemo_wreg_addr,
  output logic [15:0] exmemo_write_to_mem_data,
  output logic [1:0]  exmemo_rwe,
  output logic        exmemo_stall_request,
  output logic        exmemo_ram2_busy
);

  // PASS: normal capture. HOLD: a RAM2 access is frozen for the remaining count.
  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_e;

  // One pipeline slot worth of EX results.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] data;
    logic [3:0]  wreg_addr;
    logic [15:0] write_to_mem_data;
    logic [1:0]  rwe;
  } slot_t;

  // With a hold length of 1 the RAM2 access completes in its capture cycle.
  localparam logic       HAS_HOLD  = (RAM2_HOLD_CYCLES > 1);
  // Cycles left in HOLD after the capture edge itself.
  localparam logic [3:0] HOLD_LOAD = 4'(RAM2_HOLD_CYCLES - 1);

  localparam slot_t BUBBLE = '{
    instr:             NOP_INSTR,
    pc:                16'h0000,
    data:              16'h0000,
    wreg_addr:         4'h0,
    write_to_mem_data: 16'h0000,
    rwe:               RWE_NOTHING
  };

  state_e     state, state_next;
  slot_t      slot, slot_next;
  slot_t      slot_in;
  logic [3:0] count, count_next;
  logic       pending_flush, pending_flush_next;

  // Gather the EX inputs into one slot for a single-assignment capture.
  always_comb begin
    slot_in = '{
      instr:             exmemi_instr,
      pc:                exmemi_pc,
      data:              exmemi_data,
      wreg_addr:         exmemi_wreg_addr,
      write_to_mem_data: exmemi_write_to_mem_data,
      rwe:               exmemi_rwe
    };
  end

  // Next-state, next-contents and hold-counter decision for this edge.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next         = state;
    slot_next          = slot;
    count_next         = count;
    pending_flush_next = pending_flush;

    unique case (state)
      PASS: begin
        if (!exmemi_hold) begin
          if (exmemi_flush || pending_flush) begin
            slot_next          = BUBBLE;
            pending_flush_next = 1'b0;
          end else begin
            slot_next = slot_in;
          end
          // A bubble is never a RAM2 access, so testing slot_next covers both.
          if (HAS_HOLD && is_ram2(slot_next.rwe, slot_next.data)) begin
            state_next = HOLD;
            count_next = HOLD_LOAD;
          end
        end
      end

      HOLD: begin
        // Contents frozen; a flush arriving now is remembered for release.
        if (exmemi_flush) begin
          pending_flush_next = 1'b1;
        end
        if (count <= 4'd1) begin
          // Release edge: nothing is captured until the following edge.
          count_next = 4'd0;
          state_next = PASS;
        end else begin
          count_next = count - 4'd1;
        end
      end

      default: begin
        state_next = PASS;
        count_next = 4'd0;
      end
    endcase
  end

  // State, counter and slot registers with asynchronous reset.
  always_ff @(posedge exmemi_clk or posedge exmemi_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (exmemi_rst) begin
      // NOTE: every register, including the data payload, is reset so the mem
      // stage sees a clean NOP rather than X after power-up.
      state         <= PASS;
      slot          <= BUBBLE;
      count         <= 4'd0;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_next;
      slot          <= slot_next;
      count         <= count_next;
      pending_flush <= pending_flush_next;
    end
  end

  // Drive the latched slot and the combinational status flags.
  always_comb begin
    exmemo_instr             = slot.instr;
    exmemo_pc                = slot.pc;
    exmemo_data              = slot.data;
    exmemo_wreg_addr         = slot.wreg_addr;
    exmemo_write_to_mem_data = slot.write_to_mem_data;
    exmemo_rwe               = slot.rwe;
    // HOLD is entered on the capture edge, so it alone spans the stall window.
    exmemo_stall_request     = (state == HOLD);
    exmemo_ram2_busy         = is_ram2(slot.rwe, slot.data);
  end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Pipeline register between the execute stage and the mem stage of the 16-bit CPU.
- Captures the EX results (instr, pc, ALU data/address, write-back register, store data, rwe) and presents them to mem.
- RAM2 is shared with instruction fetch, so a load or store to RAM2 (address bit 15 = 0) is held in place for RAM2_HOLD_CYCLES cycles. During that hold the block requests an upstream freeze.
- Also implements pipeline flush (bubble insertion) and external hold.

Parameters:
RAM2_HOLD_CYCLES, 2, total cycles a RAM2 access stays latched (legal range 1..15; 1 = no extra hold)
NOP_INSTR, 16'h0800, instruction word inserted for a bubble

Ports:
exmemi_clk  in  1  system clock, all state on rising edge
exmemi_rst  in  1  asynchronous, active-high reset
exmemi_instr  in  16  instruction from EX
exmemi_pc  in  16  pc from EX
exmemi_data  in  16  ALU result / memory address from EX
exmemi_wreg_addr  in  4  destination register from EX
exmemi_write_to_mem_data  in  16  store data from EX
exmemi_rwe  in  2  access kind (RWE_* encodings of defines.v)
exmemi_hold  in  1  external freeze from hazard unit (keep contents)
exmemi_flush  in  1  replace next capture with a bubble
exmemo_instr  out  16  latched instr to mem
exmemo_pc  out  16  latched pc to mem
exmemo_data  out  16  latched data/address to mem
exmemo_wreg_addr  out  4  latched destination register to mem
exmemo_write_to_mem_data  out  16  latched store data to mem
exmemo_rwe  out  2  latched rwe to mem
exmemo_stall_request  out  1  freeze IF/ID/EX; this block is holding a RAM2 access
exmemo_ram2_busy  out  1  latched op is a RAM2 access (any hold state)

Behaviour:
- Clock is exmemi_clk; reset exmemi_rst is asynchronous, active-high.
- Reset (async, immediate) sets:
  - exmemo_instr = NOP_INSTR, exmemo_rwe = RWE_NOTHING;
  - pc, data, wreg_addr and write_to_mem_data = 0;
  - counter = 0, pending_flush = 0, state = PASS;
  - stall_request = 0, ram2_busy = 0.
- is_ram2(rwe, data): true when rwe is RWE_READ_MEM or RWE_WRITE_MEM and data[15] = 0.
- States are PASS and HOLD. Evaluate the following in order, one decision per rising edge.
- PASS:
  - If exmemi_hold = 1: keep all registers.
  - Else if exmemi_flush = 1: load a bubble (instr = NOP_INSTR, rwe = RWE_NOTHING, wreg_addr = 0, other fields = 0).
  - Else: capture all exmemi_* fields.
  - After capture, if is_ram2 of the captured values and RAM2_HOLD_CYCLES > 1: go to HOLD with counter = RAM2_HOLD_CYCLES - 1.
- HOLD:
  - All outputs stay frozen; EX inputs are ignored.
  - Counter decrements every edge regardless of exmemi_hold.
  - An exmemi_flush seen in HOLD sets pending_flush (sticky).
  - When counter = 1 at an edge: counter goes to 0 and state goes to PASS. Contents are kept, so the release edge captures nothing.
- First PASS edge after HOLD: normal PASS rules apply.
  - If pending_flush = 1 and exmemi_hold = 0: load a bubble instead of the input, and clear pending_flush.
  - A live flush in that cycle is equivalent.
- exmemo_stall_request is combinational: 1 when state = HOLD, or when state = PASS and the latched op is_ram2 on its first cycle with RAM2_HOLD_CYCLES > 1.
  - Net effect: stall_request is high for exactly RAM2_HOLD_CYCLES - 1 cycles starting the cycle after capture.
  - Upstream registers therefore see the same EX values at the release edge and may re-present them; this block captures them on the edge after release.
- exmemo_ram2_busy = is_ram2(exmemo_rwe, exmemo_data), combinational, in both states.
- Back-to-back RAM2 accesses: each gets its own full hold. The next one enters HOLD on the edge it is captured.
- RAM2_HOLD_CYCLES = 1: state never leaves PASS; stall_request is constantly 0.
- Reset mid-HOLD: all state returns to reset values immediately; pending_flush is lost.
- exmemo_ram2_busy stays high while a RAM2 op is latched and exmemi_hold = 1, but stall_request drops after the hold expires.
- No arithmetic besides the 4-bit down-counter; it never wraps below 0.

Test Plan:
- Reset check: assert rst mid-cycle -> outputs go to instr 16'h0800, rwe RWE_NOTHING, others 0, stall_request 0 immediately, without a clock edge.
- Pass-through: rwe RWE_WRITE_REG, data 16'h1234, wreg 4'h3 -> appears on outputs one edge later; stall_request stays 0.
- RAM2 load: rwe RWE_READ_MEM, data 16'h4000, default params.
  - stall_request = 1 for exactly 1 cycle and outputs stable for 2 cycles.
  - The next op (data 16'h5555, RWE_WRITE_REG) is captured on the 3rd edge.
- RAM1 store: rwe RWE_WRITE_MEM, data 16'h8010 -> ram2_busy 0, no stall.
- Flush during HOLD: RAM2_HOLD_CYCLES = 4, store to 16'h0100, flush pulsed in the 2nd hold cycle.
  - stall_request is high for 3 cycles.
  - First post-release capture is a bubble (instr 16'h0800), not the input.
- External hold plus flush, with hold = 1 and flush = 1 together -> contents unchanged; flush releases after hold drops and loads a bubble.
